// File: rtl/mul_arb_pkg.sv
// Shared definitions for the shared-multiplier sequencer: FSM state encoding,
// requester-index sizing helper and default operand/timeout constants.
package mul_arb_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    RESP
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from ptr+1 with wrap and
// returns a one-hot grant, its index and whether anything was requesting.
module rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [id_w(NUM_REQ)-1:0]   ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [id_w(NUM_REQ)-1:0]   grant_id,
  output logic                       grant_valid
);

  localparam int ID_W = id_w(NUM_REQ);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // NOTE: every output gets a default before the search loop; without it a
  // path that assigns nothing would make the tool infer a latch.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (ID_W + 1)'(i);
      if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sequencer sharing one en/done multiplier among NUM_REQ clients.
// Optional build macro MUL_TIMEOUT_EN adds a WAIT-state watchdog and resp_err.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                       clkSys,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       mul_en,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [2*WIDTH-1:0]         mul_product,
  input  logic                       mul_done,
  output logic                       resp_valid,
  output logic [id_w(NUM_REQ)-1:0]   resp_id,
  output logic [2*WIDTH-1:0]         resp_product,
  output logic                       resp_err
);

  localparam int ID_W = id_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mul_arbiter: parameter out of range");
  end

  state_t              state, state_next;
  logic [ID_W-1:0]     ptr, win_id;
  logic [NUM_REQ-1:0]  grant, ready_next;
  logic [ID_W-1:0]     grant_id;
  logic                grant_valid;
  logic                en_next, resp_next, timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (req_valid),
    .ptr         (ptr),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

`ifdef MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Zero outside WAIT, so each WAIT visit starts counting from 0.
  always_ff @(posedge clkSys or negedge rst_n) begin
    if (!rst_n)              wait_cnt <= '0;
    else if (state != WAIT)  wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    en_next    = 1'b0;
    ready_next = '0;
    resp_next  = 1'b0;
    unique case (state)
      IDLE: if (grant_valid) begin
        state_next = ISSUE;
        en_next    = 1'b1;
        ready_next = grant;
      end
      ISSUE: state_next = ARM;
      // ARM exists only so a done left over from the previous operation is skipped.
      ARM:   state_next = WAIT;
      WAIT: if (mul_done || timeout_hit) begin
        state_next = RESP;
        resp_next  = 1'b1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clkSys or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= ID_W'(NUM_REQ - 1);
      win_id       <= '0;
      req_ready    <= '0;
      mul_en       <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_product <= '0;
      resp_err     <= 1'b0;
    end else begin
      state      <= state_next;
      req_ready  <= ready_next;
      mul_en     <= en_next;
      resp_valid <= resp_next;
      if (state == IDLE && grant_valid) begin
        win_id <= grant_id;
        mul_a  <= req_a[grant_id*WIDTH +: WIDTH];
        mul_b  <= req_b[grant_id*WIDTH +: WIDTH];
      end
      if (state == ISSUE) ptr <= win_id;
      if (resp_next) begin
        resp_id      <= win_id;
        resp_err     <= timeout_hit && !mul_done;
        resp_product <= mul_done ? mul_product : '0;
      end
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: behavioural multiplier stand-in plus a
// round-robin scoreboard model; honours MUL_TIMEOUT_EN when it is defined.
`timescale 1ns/1ps
module tb_mul_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TO  = 8;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a, req_b;
  logic [N-1:0]     req_ready;
  logic             mul_en;
  logic [W-1:0]     mul_a, mul_b;
  logic [2*W-1:0]   mul_product;
  logic             mul_done;
  logic             resp_valid;
  logic [IDW-1:0]   resp_id;
  logic [2*W-1:0]   resp_product;
  logic             resp_err;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: pending requests, their operands and the last granted index.
  bit pend[N];
  int op_a[N], op_b[N];
  int rr_last;

  // Multiplier stand-in controls.
  int     mul_lat    = 2;
  bit     stale_mode = 1'b0;
  bit     never_done = 1'b0;
  int     m_cnt      = 0;
  bit     m_stale    = 1'b0;
  longint m_prod;

  always #5 clk = ~clk;

  mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clkSys       (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .mul_en       (mul_en),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_product  (mul_product),
    .mul_done     (mul_done),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .resp_err     (resp_err)
  );

  // Multiplier: en seen in cycle T gives done in cycle T+mul_lat. In stale mode
  // a leftover done stays high through the en cycle and the cycle after it.
  always begin
    @(posedge clk); #1;
    if (mul_en) begin
      m_cnt   = mul_lat;
      m_prod  = longint'($signed(mul_a)) * longint'($signed(mul_b));
      m_stale = stale_mode;
      if (!m_stale) mul_done = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && !never_done) begin
        mul_done    = 1'b1;
        mul_product = m_prod;
      end else if (m_stale) begin
        m_stale  = 1'b0;
        mul_done = 1'b1;
      end else begin
        mul_done = 1'b0;
      end
    end else if (!stale_mode) begin
      mul_done = 1'b0;
    end
  end

  // Requesters may only drop req_valid once their req_ready has been seen.
  logic [N-1:0] prev_valid = '0;
  logic [N-1:0] granted    = '0;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) granted[i] = 1'b1;
      if (prev_valid[i] && !req_valid[i]) begin
        checks++;
        if (!granted[i]) begin
          failures++;
          $display("FAIL protocol: req_valid[%0d] dropped without req_ready", i);
        end
      end
      if (!req_valid[i]) granted[i] = 1'b0;
    end
    prev_valid = req_valid;
  end

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (rr_last + k) % N;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic post(input int i, input int a, input int b);
    pend[i] = 1'b1;
    op_a[i] = a;
    op_b[i] = b;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    rr_last = N - 1;
  endtask

  // One full transaction against the model: grant, operands, latency, response.
  task automatic serve(input int lat, output int got, output int grant_wait);
    int w, c;
    logic [63:0] exp_p;
    got = -1;
    grant_wait = 0;
    w = pick();
    mul_lat = lat;
    checks++;
    if (w < 0) begin
      failures++;
      $display("FAIL serve_setup: no pending request got=%0d need>=0", w);
      return;
    end
    c = 0;
    do begin @(posedge clk); #1; c++; end while (req_ready == '0 && c < 30);
    grant_wait = c;
    checks++;
    if (req_ready !== N'(1 << w)) begin
      failures++;
      $display("FAIL grant: req_ready=%b need=%b", req_ready, N'(1 << w));
    end
    checks++;
    if (mul_en !== 1'b1) begin
      failures++;
      $display("FAIL mul_en: got=%b need=1", mul_en);
    end
    checks++;
    if (mul_a !== W'(op_a[w]) || mul_b !== W'(op_b[w])) begin
      failures++;
      $display("FAIL operands: a=%h b=%h need a=%h b=%h", mul_a, mul_b, W'(op_a[w]), W'(op_b[w]));
    end
    if (req_ready == '0) return;
    pend[w] = 1'b0;
    req_valid[w] = 1'b0;
    rr_last = w;
    got = w;
    exp_p = 64'(longint'(op_a[w]) * longint'(op_b[w]));
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!resp_valid && c < lat + 30);
    checks++;
    if (!resp_valid) begin
      failures++;
      $display("FAIL resp_timeout: no resp_valid within %0d cycles", c);
      return;
    end
    checks++;
    if (c != lat + 1) begin
      failures++;
      $display("FAIL resp_latency: got=%0d need=%0d", c, lat + 1);
    end
    checks++;
    if (resp_id !== IDW'(w) || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL resp_tag: id=%0d err=%b need id=%0d err=0", resp_id, resp_err, w);
    end
    checks++;
    if (resp_product !== exp_p) begin
      failures++;
      $display("FAIL resp_product: got=%h need=%h", resp_product, exp_p);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (req_ready !== '0 || mul_en !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b en=%b rv=%b need 0", req_ready, mul_en, resp_valid);
    end
    checks++;
    if (mul_a !== '0 || mul_b !== '0) begin
      failures++;
      $display("FAIL reset_operands: a=%h b=%h need 0", mul_a, mul_b);
    end
    checks++;
    if (resp_id !== '0 || resp_product !== '0 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp: id=%0d p=%h err=%b need 0", resp_id, resp_product, resp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rr_last = N - 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mul_en !== 1'b0 || req_ready !== '0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet: en=%b ready=%b rv=%b need 0", mul_en, req_ready, resp_valid);
    end
  endtask

  task automatic test_single();
    int got, gw;
    @(negedge clk);
    post(2, 5, -5);
    serve(3, got, gw);
    checks++;
    if (gw != 1 || got != 2) begin
      failures++;
      $display("FAIL single_grant: wait=%0d id=%0d need wait=1 id=2", gw, got);
    end
    checks++;
    if (resp_product !== 64'hFFFF_FFFF_FFFF_FFE7) begin
      failures++;
      $display("FAIL single_product: got=%h need=%h", resp_product, 64'hFFFF_FFFF_FFFF_FFE7);
    end
  endtask

  task automatic test_all_four();
    int got, gw;
    do_reset();
    for (int i = 0; i < N; i++) post(i, i + 1, -(i + 1));
    for (int i = 0; i < N; i++) begin
      serve(2 + i, got, gw);
      checks++;
      if (got != i || resp_product !== 64'(-longint'((i + 1) * (i + 1)))) begin
        failures++;
        $display("FAIL all_four: id=%0d p=%h need id=%0d p=%0d", got, resp_product, i, -(i + 1) * (i + 1));
      end
    end
  endtask

  task automatic test_stale_done();
    int got, gw;
    mul_product = 64'hDEAD_BEEF_0BAD_F00D;
    stale_mode  = 1'b1;
    mul_done    = 1'b1;
    @(posedge clk); #1;
    post(1, 7, 6);
    serve(3, got, gw);
    checks++;
    if (got != 1 || resp_product !== 64'd42) begin
      failures++;
      $display("FAIL stale_done: id=%0d p=%h need id=1 p=42", got, resp_product);
    end
    stale_mode = 1'b0;
    mul_done   = 1'b0;
  endtask

  task automatic test_extremes();
    int got, gw, w;
    logic [63:0] exp_p;
    post(3, int'(32'h8000_0000), int'(32'h8000_0000));
    post(0, -1, 1);
    for (int k = 0; k < 2; k++) begin
      w = pick();
      exp_p = (w == 3) ? 64'h4000_0000_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
      serve(4, got, gw);
      checks++;
      if (resp_product !== exp_p) begin
        failures++;
        $display("FAIL extremes: id=%0d p=%h need=%h", got, resp_product, exp_p);
      end
    end
  endtask

  task automatic test_back_to_back();
    int got, gw, start;
    for (int i = 0; i < N; i++) post(i, $urandom, $urandom);
    start = (rr_last + 1) % N;
    for (int i = 0; i < 2 * N; i++) begin
      serve(2, got, gw);
      checks++;
      if (got != (start + i) % N) begin
        failures++;
        $display("FAIL fairness: id=%0d need=%0d", got, (start + i) % N);
      end
      if (got >= 0) post(got, $urandom, $urandom);
    end
  endtask

  task automatic test_random();
    int got, gw, any;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) post(i, $urandom, $urandom);
      any = 0;
      for (int i = 0; i < N; i++) if (pend[i]) any = 1;
      if (any == 0) post($urandom_range(0, N - 1), $urandom, $urandom);
      serve($urandom_range(2, 6), got, gw);
    end
    for (int k = 0; k < N; k++)
      if (pick() >= 0) serve($urandom_range(2, 6), got, gw);
  endtask

  task automatic test_reset_abort();
    int got, gw, c;
    bit seen;
    do_reset();
    post(0, 11, 3);
    post(1, -9, 8);
    mul_lat = 40;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (req_ready == '0 && c < 30);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL abort_grant: req_ready=%b need=0001", req_ready);
    end
    req_valid[0] = 1'b0;
    pend[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, mul_en, mul_a, mul_b, resp_valid, resp_id, resp_product, resp_err} !== '0) begin
      failures++;
      $display("FAIL abort_async: en=%b a=%h b=%h rv=%b p=%h need all 0", mul_en, mul_a, mul_b, resp_valid, resp_product);
    end
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_resp: resp_valid=1 during reset need 0");
    end
    @(negedge clk);
    rst_n   = 1'b1;
    rr_last = N - 1;
    serve(4, got, gw);
    checks++;
    if (got != 1) begin
      failures++;
      $display("FAIL abort_regrant: id=%0d need=1", got);
    end
  endtask

  task automatic test_timeout();
    int c;
    never_done = 1'b1;
    mul_lat = 2;
    post(2, 3, 4);
    c = 0;
    do begin @(posedge clk); #1; c++; end while (req_ready == '0 && c < 30);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL timeout_grant: req_ready=%b need=0100", req_ready);
    end
    req_valid[2] = 1'b0;
    pend[2] = 1'b0;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!resp_valid && c < 40);
`ifdef MUL_TIMEOUT_EN
    checks++;
    if (!resp_valid || c != TO + 2) begin
      failures++;
      $display("FAIL timeout_latency: rv=%b cycles=%0d need rv=1 cycles=%0d", resp_valid, c, TO + 2);
    end
    checks++;
    if (resp_err !== 1'b1 || resp_product !== '0 || resp_id !== 2'd2) begin
      failures++;
      $display("FAIL timeout_resp: err=%b p=%h id=%0d need err=1 p=0 id=2", resp_err, resp_product, resp_id);
    end
    rr_last = 2;
`else
    checks++;
    if (resp_valid) begin
      failures++;
      $display("FAIL no_timeout: resp_valid=1 after %0d cycles need none", c);
    end
    do_reset();
`endif
    never_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    mul_done    = 1'b0;
    mul_product = '0;
    rr_last     = N - 1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_stale_done();
    test_extremes();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
